neuron_input_bank: RTL and testbench

Parametrised successor to the 4x8-bit neuron input shift register. Holds N_CH registered neuron inputs shared by every neuron of the current layer. Supports four modes:
- load external data through a valid/ready handshake
- hold
- reload from the neuron outputs (layer feedback)
- drain results through a valid/ready output stream

Sits between the network data source, the per-layer neuron array and the layer-sequencing state machine.

---
 rtl/neuron_input_bank_if.sv | 23 ++
 rtl/neuron_input_bank.sv | 105 ++++++++++
 tb/tb_neuron_input_bank.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_input_bank_if.sv
// Stream interface of the neuron input bank.
// It carries the external load stream (in_*) and the drain stream (out_*).
// The master is the data source/sink side. The slave is the bank.
interface neuron_input_bank_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/neuron_input_bank.sv
// neuron_input_bank: N_CH registered neuron inputs shared by one layer.
// Modes (driven by the layer sequencer):
//   00 LOAD_EXT : shift in external words; a full bank drops the word and sets err.
//   01 HOLD     : keep all state.
//   10 FEEDBACK : reload every channel from the neuron outputs.
//   11 DRAIN    : shift words out of r[N_CH-1] onto the output stream.
// Optional build macro NEURON_INPUT_BANK_RELU_EN: when it is defined,
// FEEDBACK loads negative neuron outputs as zero.
// The DATA_W of the interface instance must match the DATA_W of this module.
module neuron_input_bank #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [1:0]               mode,
  neuron_input_bank_if.slave       bus,
  input  logic [N_CH*DATA_W-1:0]   neuron_out,
  output logic [N_CH*DATA_W-1:0]   neuron_in,
  output logic [CNT_W-1:0]         fill_cnt,
  output logic                     bank_full,
  output logic                     err
);

  localparam logic [1:0]       LOAD_EXT = 2'b00;
  localparam logic [1:0]       FEEDBACK = 2'b10;
  localparam logic [1:0]       DRAIN    = 2'b11;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_CH);

  logic [DATA_W-1:0] r     [N_CH];
  logic [DATA_W-1:0] r_nxt [N_CH];
  logic [CNT_W-1:0]  cnt_nxt;
  logic              err_nxt;
  logic              load_fire;
  logic              drain_fire;

`ifdef NEURON_INPUT_BANK_RELU_EN
  // Negative (two's complement) activations are clamped to zero on reload.
  function automatic logic [DATA_W-1:0] fb_word(input logic [DATA_W-1:0] w);
    return w[DATA_W-1] ? '0 : w;
  endfunction
`else
  // Activations are reloaded verbatim.
  function automatic logic [DATA_W-1:0] fb_word(input logic [DATA_W-1:0] w);
    return w;
  endfunction
`endif

  // The handshakes depend only on registered state and mode. Both are held low during reset.
  assign bus.in_ready  = !rstn && (mode == LOAD_EXT) && (fill_cnt < FULL_CNT);
  assign bus.out_valid = !rstn && (mode == DRAIN) && (fill_cnt != '0);
  assign bus.out_data  = r[N_CH-1];
  assign load_fire     = bus.in_valid && bus.in_ready;
  assign drain_fire    = bus.out_valid && bus.out_ready;
  assign bank_full     = (fill_cnt == FULL_CNT);

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign neuron_in[g*DATA_W +: DATA_W] = r[g];
  end

  // Next-state of the storage, the fill count and the sticky overrun flag.
  always_comb begin
    r_nxt   = r;
    cnt_nxt = fill_cnt;
    err_nxt = err;
    case (mode)
      LOAD_EXT: begin
        if (load_fire) begin
          r_nxt[0] = bus.in_data;
          for (int i = 1; i < N_CH; i++) r_nxt[i] = r[i-1];
          cnt_nxt = fill_cnt + CNT_W'(1);
        end else if (bus.in_valid && (fill_cnt == FULL_CNT)) begin
          err_nxt = 1'b1;
        end
      end
      FEEDBACK: begin
        for (int i = 0; i < N_CH; i++) r_nxt[i] = fb_word(neuron_out[i*DATA_W +: DATA_W]);
        cnt_nxt = FULL_CNT;
      end
      DRAIN: begin
        if (drain_fire) begin
          r_nxt[0] = '0;
          for (int i = 1; i < N_CH; i++) r_nxt[i] = r[i-1];
          cnt_nxt = fill_cnt - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // State registers. An asynchronous reset discards all contents.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < N_CH; i++) r[i] <= '0;
      fill_cnt <= '0;
      err      <= 1'b0;
    end else begin
      r        <= r_nxt;
      fill_cnt <= cnt_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_neuron_input_bank.sv
// Testbench for neuron_input_bank (DATA_W=8, N_CH=4).
// It applies a directed vector table, hand-written reset and feedback
// sequences, and random traffic checked against a queue-based model.
module tb_neuron_input_bank;
  localparam int DATA_W = 8;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 3;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [1:0]             mode;
  logic [N_CH*DATA_W-1:0] neuron_out;
  logic [N_CH*DATA_W-1:0] neuron_in;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   bank_full;
  logic                   err;

  neuron_input_bank_if #(.DATA_W(DATA_W)) bus ();

  neuron_input_bank #(.DATA_W(DATA_W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .bus(bus),
    .neuron_out(neuron_out), .neuron_in(neuron_in),
    .fill_cnt(fill_cnt), .bank_full(bank_full), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  md;
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic [31:0] nout;
    logic        ir;
    logic        ov;
    logic [7:0]  od;
    logic [31:0] ni;
    logic [2:0]  cnt;
    logic        er;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] md, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic [31:0] nout, input logic ir,
                              input logic ov, input logic [7:0] od, input logic [31:0] ni,
                              input logic [2:0] cnt, input logic er);
    vec_t v;
    v.md = md; v.iv = iv; v.id = id; v.ordy = ordy; v.nout = nout;
    v.ir = ir; v.ov = ov; v.od = od; v.ni = ni; v.cnt = cnt; v.er = er;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // mq[i] is channel i. A push inserts at the front and drops the back word.
  logic [DATA_W-1:0] mq[$];
  int                mcnt;
  bit                merr;

  function automatic logic [DATA_W-1:0] fb_word(input logic [DATA_W-1:0] w);
`ifdef NEURON_INPUT_BANK_RELU_EN
    if ($signed(w) < 0) return '0;
`endif
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N_CH; i++) mq.push_back('0);
    mcnt = 0;
    merr = 0;
  endtask

  function automatic logic [N_CH*DATA_W-1:0] model_pack();
    logic [N_CH*DATA_W-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i*DATA_W +: DATA_W] = mq[i];
    return v;
  endfunction

  // The inputs are already applied. This task checks the handshake outputs and advances the model by one cycle.
  task automatic model_cycle();
    bit exp_ir, exp_ov;
    exp_ir = (mode == 2'b00) && (mcnt < N_CH);
    exp_ov = (mode == 2'b11) && (mcnt != 0);
    check("rnd in_ready", bus.in_ready, exp_ir);
    check("rnd out_valid", bus.out_valid, exp_ov);
    if (exp_ov) check("rnd out_data", bus.out_data, mq[N_CH-1]);
    case (mode)
      2'b00: if (bus.in_valid) begin
        if (mcnt < N_CH) begin
          mq.push_front(bus.in_data);
          void'(mq.pop_back());
          mcnt++;
        end else merr = 1;
      end
      2'b10: begin
        for (int i = 0; i < N_CH; i++) mq[i] = fb_word(neuron_out[i*DATA_W +: DATA_W]);
        mcnt = N_CH;
      end
      2'b11: if (exp_ov && bus.out_ready) begin
        mq.push_front('0);
        void'(mq.pop_back());
        mcnt--;
      end
      default: ;
    endcase
  endtask

  task automatic model_check_regs();
    check("rnd neuron_in", neuron_in, model_pack());
    check("rnd fill_cnt", fill_cnt, mcnt);
    check("rnd bank_full", bank_full, mcnt == N_CH);
    check("rnd err", err, merr);
  endtask

  initial begin
    logic [31:0] exp_fb;

    // ---- reset state (the mode is LOAD_EXT so that the forced-low in_ready is tested) ----
    rstn = 1'b1;
    mode = 2'b00;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b1;
    neuron_out = 32'hDEADBEEF;
    #2;
    check("reset fill_cnt", fill_cnt, 0);
    check("reset neuron_in", neuron_in, 0);
    check("reset err", err, 0);
    check("reset in_ready", bus.in_ready, 0);
    check("reset bank_full", bank_full, 0);
    mode = 2'b11;
    #1;
    check("reset out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;

    // ---- directed table ----
    // fields: mode iv id ordy nout | ir ov od (before the edge) | ni cnt err (after the edge)
    vq.push_back(mk(2'b00, 1, 8'h11, 0, 32'h0, 1, 0, 8'h00, 32'h00000011, 3'd1, 0));
    vq.push_back(mk(2'b00, 1, 8'h22, 0, 32'h0, 1, 0, 8'h00, 32'h00001122, 3'd2, 0));
    vq.push_back(mk(2'b00, 1, 8'h33, 0, 32'h0, 1, 0, 8'h00, 32'h00112233, 3'd3, 0));
    vq.push_back(mk(2'b00, 1, 8'h44, 0, 32'h0, 1, 0, 8'h00, 32'h11223344, 3'd4, 0));
    vq.push_back(mk(2'b00, 1, 8'h55, 0, 32'h0, 0, 0, 8'h11, 32'h11223344, 3'd4, 1));
    vq.push_back(mk(2'b10, 0, 8'h00, 0, 32'h08070605, 0, 0, 8'h11, 32'h08070605, 3'd4, 1));
    vq.push_back(mk(2'b11, 0, 8'h00, 1, 32'h0, 0, 1, 8'h08, 32'h07060500, 3'd3, 1));
    vq.push_back(mk(2'b11, 0, 8'h00, 0, 32'h0, 0, 1, 8'h07, 32'h07060500, 3'd3, 1));
    vq.push_back(mk(2'b11, 0, 8'h00, 1, 32'h0, 0, 1, 8'h07, 32'h06050000, 3'd2, 1));
    vq.push_back(mk(2'b11, 0, 8'h00, 1, 32'h0, 0, 1, 8'h06, 32'h05000000, 3'd1, 1));
    vq.push_back(mk(2'b11, 0, 8'h00, 1, 32'h0, 0, 1, 8'h05, 32'h00000000, 3'd0, 1));
    vq.push_back(mk(2'b11, 0, 8'h00, 1, 32'h0, 0, 0, 8'h00, 32'h00000000, 3'd0, 1));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(2'b01, 1, 8'hAA, 0, 32'h0, 0, 0, 8'h00, 32'h00000000, 3'd0, 1));

    foreach (vq[k]) begin
      mode = vq[k].md; bus.in_valid = vq[k].iv; bus.in_data = vq[k].id;
      bus.out_ready = vq[k].ordy; neuron_out = vq[k].nout;
      #1;
      check($sformatf("vec%0d in_ready", k), bus.in_ready, vq[k].ir);
      check($sformatf("vec%0d out_valid", k), bus.out_valid, vq[k].ov);
      check($sformatf("vec%0d out_data", k), bus.out_data, vq[k].od);
      @(posedge clk); #1;
      check($sformatf("vec%0d neuron_in", k), neuron_in, vq[k].ni);
      check($sformatf("vec%0d fill_cnt", k), fill_cnt, vq[k].cnt);
      check($sformatf("vec%0d bank_full", k), bank_full, vq[k].cnt == 3'd4);
      check($sformatf("vec%0d err", k), err, vq[k].er);
    end

    // ---- asynchronous reset in the middle of a load ----
    mode = 2'b00; bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_data = 8'h22;
    @(posedge clk); #1;
    check("midload fill_cnt", fill_cnt, 2);
    bus.in_valid = 1'b0;
    #2 rstn = 1'b1;
    #1;
    check("async fill_cnt", fill_cnt, 0);
    check("async neuron_in", neuron_in, 0);
    check("async in_ready", bus.in_ready, 0);
    check("async err", err, 0);
    #2 rstn = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    #1;
    check("post-reset in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("post-reset neuron_in", neuron_in, 32'h00000033);
    check("post-reset fill_cnt", fill_cnt, 1);

    // ---- feedback with one negative channel ----
`ifdef NEURON_INPUT_BANK_RELU_EN
    exp_fb = 32'h01010001;
`else
    exp_fb = 32'h01019001;
`endif
    mode = 2'b10; neuron_out = 32'h01019001;
    @(posedge clk); #1;
    mode = 2'b01;
    check("relu neuron_in", neuron_in, exp_fb);
    check("relu fill_cnt", fill_cnt, 4);

    // ---- random traffic against the model ----
    rstn = 1'b1;
    #2 rstn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int c = 0; c < 2000; c++) begin
      mode          = 2'($urandom_range(0, 3));
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom);
      neuron_out    = $urandom;
      #1;
      model_cycle();
      @(posedge clk); #1;
      model_check_regs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
